// File: rtl/cancel_accumulator_if.sv
// Event, RAM and update-report signal bundle for cancel_accumulator.
interface cancel_accumulator_if #(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 4,
  parameter int AMT_WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_client;
  logic [AMT_WIDTH-1:0] in_amount;
  logic                 in_clear;
  logic [A_WIDTH-1:0]   ram_address_read;
  logic [D_WIDTH-1:0]   ram_data_read;
  logic [A_WIDTH-1:0]   ram_address_write;
  logic [D_WIDTH-1:0]   ram_data_write;
  logic                 ram_write_enable;
  logic                 upd_valid;
  logic [A_WIDTH-1:0]   upd_client;
  logic [D_WIDTH-1:0]   upd_total;
  logic                 init_done;
  logic                 sat_pulse;

  modport slave (
    input  in_valid, in_client, in_amount, in_clear, ram_data_read,
    output in_ready, ram_address_read, ram_address_write, ram_data_write,
           ram_write_enable, upd_valid, upd_client, upd_total, init_done, sat_pulse
  );

  modport master (
    output in_valid, in_client, in_amount, in_clear, ram_data_read,
    input  in_ready, ram_address_read, ram_address_write, ram_data_write,
           ram_write_enable, upd_valid, upd_client, upd_total, init_done, sat_pulse
  );
endinterface

// File: rtl/cancel_accumulator.sv
// Per-client cancelled-amount accumulator over an external 1-cycle-latency RAM.
// Define CANCEL_ACC_SAT_EN to clamp totals at all-ones instead of wrapping.
module cancel_accumulator #(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 4,
  parameter int A_MAX     = 16,
  parameter int AMT_WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  cancel_accumulator_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [A_WIDTH:0]     init_cnt;
  logic                 in_ready_q;
  logic                 init_done_q;

  logic                 s1_valid;
  logic [A_WIDTH-1:0]   s1_client;
  logic [AMT_WIDTH-1:0] s1_amount;
  logic                 s1_clear;

  logic                 wr_en_q;
  logic                 upd_q;
  logic [A_WIDTH-1:0]   wr_addr_q;
  logic [D_WIDTH-1:0]   wr_data_q;

  logic                 dly_valid;
  logic [A_WIDTH-1:0]   dly_addr;
  logic [D_WIDTH-1:0]   dly_data;

  logic [D_WIDTH-1:0]   base;
  logic [D_WIDTH-1:0]   new_total;

  assign bus.ram_address_read  = bus.in_client;
  assign bus.in_ready          = in_ready_q;
  assign bus.init_done         = init_done_q;
  assign bus.ram_address_write = wr_addr_q;
  assign bus.ram_data_write    = wr_data_q;
  assign bus.ram_write_enable  = wr_en_q;
  assign bus.upd_valid         = upd_q;
  assign bus.upd_client        = wr_addr_q;
  assign bus.upd_total         = wr_data_q;

  // The RAM read misses the write in the write registers and the one it is
  // committing this edge, so both are forwarded, newest first.
  always_comb begin
    base = bus.ram_data_read;
    if (wr_en_q && wr_addr_q == s1_client)
      base = wr_data_q;
    else if (dly_valid && dly_addr == s1_client)
      base = dly_data;
  end

`ifdef CANCEL_ACC_SAT_EN
  logic [D_WIDTH:0] sum;
  logic             new_sat;
  logic             sat_q;

  always_comb begin
    sum     = {1'b0, base} + (D_WIDTH+1)'(s1_amount);
    new_sat = !s1_clear && sum[D_WIDTH];
    if (s1_clear)          new_total = '0;
    else if (sum[D_WIDTH]) new_total = '1;
    else                   new_total = sum[D_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= s1_valid && new_sat;
  end

  assign bus.sat_pulse = sat_q;
`else
  logic [D_WIDTH-1:0] sum;

  always_comb begin
    sum       = base + D_WIDTH'(s1_amount);
    new_total = s1_clear ? '0 : sum;
  end

  assign bus.sat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      in_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
      s1_valid    <= 1'b0;
      s1_client   <= '0;
      s1_amount   <= '0;
      s1_clear    <= 1'b0;
      wr_en_q     <= 1'b0;
      upd_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dly_valid   <= 1'b0;
      dly_addr    <= '0;
      dly_data    <= '0;
    end else begin
      dly_valid <= wr_en_q;
      dly_addr  <= wr_addr_q;
      dly_data  <= wr_data_q;
      case (state)
        INIT: begin
          upd_q    <= 1'b0;
          s1_valid <= 1'b0;
          if (init_cnt < (A_WIDTH+1)'(A_MAX)) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= init_cnt[A_WIDTH-1:0];
            wr_data_q <= '0;
            init_cnt  <= init_cnt + 1'b1;
          end else begin
            wr_en_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            init_done_q <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          s1_valid  <= bus.in_valid && in_ready_q;
          s1_client <= bus.in_client;
          s1_amount <= bus.in_amount;
          s1_clear  <= bus.in_clear;
          wr_en_q   <= s1_valid;
          upd_q     <= s1_valid;
          if (s1_valid) begin
            wr_addr_q <= s1_client;
            wr_data_q <= new_total;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cancel_accumulator.sv
// Self-checking bench for cancel_accumulator: RAM model, per-client total model,
// per-cycle output comparison and literal checks on the logged updates.
module tb_cancel_accumulator;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int AM = 16;
  localparam int MW = 16;
`ifdef CANCEL_ACC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  cancel_accumulator_if #(.D_WIDTH(DW), .A_WIDTH(AW), .AMT_WIDTH(MW)) bus ();

  cancel_accumulator #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .AMT_WIDTH(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous RAM with a backdoor write for preloading.
  logic [DW-1:0] mem [AM];
  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address_write] <= bus.ram_data_write;
    if (poke_en) mem[poke_addr] <= poke_data;
    bus.ram_data_read <= mem[bus.ram_address_read];
  end

  // Model: each accepted event becomes the write seen one cycle after the
  // following edge, computed from a plain array of totals.
  logic [DW-1:0] m_tot [AM];
  logic          m_rst, m_ready, m_pend, m_pclr;
  logic [AW-1:0] m_pc;
  logic [MW-1:0] m_pa;
  int            m_idx;
  logic          e_wen, e_upd, e_sat;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  always @(posedge clk) begin : model
    logic [DW:0]   s;
    logic [DW-1:0] nv;
    logic          ns;
    if (poke_en) m_tot[poke_addr] <= poke_data;
    if (!rst_n) begin
      m_rst <= 1'b1; m_ready <= 1'b0; m_idx <= 0; m_pend <= 1'b0;
      e_wen <= 1'b0; e_upd <= 1'b0; e_sat <= 1'b0; e_waddr <= '0; e_wdata <= '0;
    end else begin
      m_rst <= 1'b0;
      if (m_idx < AM) begin
        e_wen <= 1'b1; e_upd <= 1'b0; e_sat <= 1'b0;
        e_waddr <= AW'(m_idx); e_wdata <= '0;
        m_tot[m_idx] <= '0;
        m_idx <= m_idx + 1;
        m_ready <= 1'b0; m_pend <= 1'b0;
      end else begin
        m_ready <= 1'b1;
        m_pend  <= m_ready && bus.in_valid;
        m_pc    <= bus.in_client;
        m_pa    <= bus.in_amount;
        m_pclr  <= bus.in_clear;
        e_wen   <= m_pend;
        e_upd   <= m_pend;
        e_sat   <= 1'b0;
        if (m_pend) begin
          s  = {1'b0, m_tot[m_pc]} + (DW+1)'(m_pa);
          nv = s[DW-1:0];
          ns = 1'b0;
          if (SAT && s[DW]) begin nv = '1; ns = 1'b1; end
          if (m_pclr) begin nv = '0; ns = 1'b0; end
          m_tot[m_pc] <= nv;
          e_waddr <= m_pc;
          e_wdata <= nv;
          e_sat   <= ns;
        end
      end
    end
  end

  typedef struct packed {
    logic          upd;
    logic          sat;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t wlog [$];
  wr_t ulog [$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
    chk("init_done", 64'(bus.init_done), 64'(m_ready));
    chk("ram_write_enable", 64'(bus.ram_write_enable), 64'(e_wen));
    chk("upd_valid", 64'(bus.upd_valid), 64'(e_upd));
    chk("sat_pulse", 64'(bus.sat_pulse), 64'(e_sat));
    chk("ram_address_read", 64'(bus.ram_address_read), 64'(bus.in_client));
    if (e_wen) begin
      chk("ram_address_write", 64'(bus.ram_address_write), 64'(e_waddr));
      chk("ram_data_write", 64'(bus.ram_data_write), 64'(e_wdata));
    end
    if (e_upd) begin
      chk("upd_client", 64'(bus.upd_client), 64'(e_waddr));
      chk("upd_total", 64'(bus.upd_total), 64'(e_wdata));
    end
    if (m_rst) begin
      chk("rst_waddr", 64'(bus.ram_address_write), 64'd0);
      chk("rst_wdata", 64'(bus.ram_data_write), 64'd0);
    end
    if (bus.ram_write_enable)
      wlog.push_back('{bus.upd_valid, bus.sat_pulse, bus.ram_address_write, bus.ram_data_write});
    if (bus.upd_valid)
      ulog.push_back('{bus.upd_valid, bus.sat_pulse, bus.upd_client, bus.upd_total});
  endtask

  task automatic drive(input logic v, input int c, input int a, input logic clr);
    bus.in_valid  = v;
    bus.in_client = AW'(c);
    bus.in_amount = MW'(a);
    bus.in_clear  = clr;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    poke_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic expect_upd(input int i, input int a, input logic [DW-1:0] d, input logic s);
    if (i < ulog.size()) begin
      chk("log_client", 64'(ulog[i].a), 64'(a));
      chk("log_total", 64'(ulog[i].d), 64'(d));
      chk("log_sat", 64'(ulog[i].sat), 64'(s));
    end else begin
      chk("log_missing", 64'(ulog.size()), 64'(i + 1));
    end
  endtask

  // Reset (optionally with an event still presented), then INIT sweep.
  task automatic do_init(input logic v);
    int first_ready;
    wlog.delete();
    ulog.delete();
    rst_n = 1'b0;
    drive(v, 4, 11, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    first_ready = -1;
    for (int k = 1; k <= 40 && first_ready < 0; k++) begin
      drive(1'b0, 0, 0, 1'b0);
      if (bus.in_ready) first_ready = k;
    end
    chk("init_ready_cycle", 64'(first_ready), 64'd17);
    chk("init_write_count", 64'(wlog.size()), 64'(AM));
    for (int i = 0; i < AM && i < wlog.size(); i++) begin
      chk("init_addr", 64'(wlog[i].a), 64'(i));
      chk("init_data", 64'(wlog[i].d), 64'd0);
      chk("init_upd", 64'(wlog[i].upd), 64'd0);
    end
    chk("init_no_upd", 64'(ulog.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    bus.in_valid = 1'b0; bus.in_client = '0; bus.in_amount = '0; bus.in_clear = 1'b0;
    idle(2);
    do_init(1'b0);

    // Same client on consecutive cycles.
    ulog.delete();
    drive(1'b1, 3, 5, 1'b0);
    drive(1'b1, 3, 7, 1'b0);
    idle(3);
    expect_upd(0, 3, 32'd5, 1'b0);
    expect_upd(1, 3, 32'd12, 1'b0);

    // Interleaved clients, both forwarding depths.
    ulog.delete();
    drive(1'b1, 2, 1, 1'b0);
    drive(1'b1, 9, 4, 1'b0);
    drive(1'b1, 2, 2, 1'b0);
    drive(1'b1, 2, 3, 1'b0);
    idle(3);
    expect_upd(0, 2, 32'd1, 1'b0);
    expect_upd(1, 9, 32'd4, 1'b0);
    expect_upd(2, 2, 32'd3, 1'b0);
    expect_upd(3, 2, 32'd6, 1'b0);
    chk("model_tot2", 64'(m_tot[2]), 64'd6);
    chk("model_tot9", 64'(m_tot[9]), 64'd4);

    // Clear ignores amount; following add starts from zero.
    ulog.delete();
    drive(1'b1, 5, 100, 1'b0);
    idle(3);
    drive(1'b1, 5, 50, 1'b1);
    drive(1'b1, 5, 8, 1'b0);
    idle(3);
    expect_upd(0, 5, 32'd100, 1'b0);
    expect_upd(1, 5, 32'd0, 1'b0);
    expect_upd(2, 5, 32'd8, 1'b0);

    // Every-cycle burst to one client.
    ulog.delete();
    for (int i = 1; i <= 6; i++) drive(1'b1, 7, i, 1'b0);
    idle(3);
    expect_upd(5, 7, 32'd21, 1'b0);
    chk("model_tot7", 64'(m_tot[7]), 64'd21);

    // Overflow: clamp or wrap depending on the build.
    ulog.delete();
    poke_en = 1'b1; poke_addr = 4'd1; poke_data = 32'hFFFF_FFF0;
    drive(1'b0, 0, 0, 1'b0);
    drive(1'b1, 1, 32'h20, 1'b0);
    idle(3);
    expect_upd(0, 1, SAT ? 32'hFFFF_FFFF : 32'h0000_0010, SAT);

    // Mid-flight reset: one event in S1, another presented at the reset edge.
    drive(1'b1, 4, 9, 1'b0);
    do_init(1'b1);
    chk("model_tot4", 64'(m_tot[4]), 64'd0);

    // Back in RUN after the restart.
    ulog.delete();
    drive(1'b1, 4, 3, 1'b0);
    drive(1'b1, 4, 4, 1'b0);
    idle(3);
    expect_upd(0, 4, 32'd3, 1'b0);
    expect_upd(1, 4, 32'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cancel_accumulator.md
CANCEL_ACCUMULATOR -- requirements
Module: cancel_accumulator

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, accumulated-total width.
REQ-002 SHALL have parameter A_WIDTH, default 4, client-ID width.
REQ-003 SHALL have parameter A_MAX, default 16, number of clients (2^A_WIDTH).
REQ-004 SHALL have parameter AMT_WIDTH, default 16, width of one cancelled-order amount.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, cancel event present.
REQ-008 SHALL have port in_ready, output, 1, block accepts an event this cycle.
REQ-009 SHALL have port in_client, input, A_WIDTH, client ID of the event.
REQ-010 SHALL have port in_amount, input, AMT_WIDTH, cancelled amount.
REQ-011 SHALL have port in_clear, input, 1, 1 = reset this client's total to 0, ignoring in_amount.
REQ-012 SHALL have port ram_address_read, output, A_WIDTH, RAM read address.
REQ-013 SHALL have port ram_data_read, input, D_WIDTH, RAM read data, registered by the RAM one edge after the address.
REQ-014 SHALL have ports ram_address_write (A_WIDTH), ram_data_write (D_WIDTH) and ram_write_enable (1), outputs, RAM write port; all three SHALL be registered.
REQ-015 SHALL have ports upd_valid (1), upd_client (A_WIDTH) and upd_total (D_WIDTH), outputs, a report of each accumulated update.
REQ-016 SHALL have ports init_done (1) and sat_pulse (1), outputs, RAM initialised and clamp-occurred indicators.

Function
REQ-017 SHALL run a state machine with states INIT and RUN; reset SHALL enter INIT.
REQ-018 INIT SHALL write 0 to addresses 0..A_MAX-1, one per cycle, with ram_write_enable=1, and then enter RUN; in_ready=0 and init_done=0 throughout INIT.
REQ-019 In RUN, in_ready=1 and init_done=1 SHALL hold every cycle, with no backpressure.
REQ-020 An event SHALL be accepted on a clk edge where in_valid && in_ready; ram_address_read SHALL equal in_client combinationally.
REQ-021 Pipeline, for an event accepted at edge E0:
- S1 (E0..E1): computes new = base + zero-extended in_amount, or new = 0 if in_clear.
- E1: the write registers load; ram_write_enable=1 and upd_valid=1 for exactly one cycle.
- E2: the RAM commits.
REQ-022 base SHALL be chosen as follows:
- the write-register data if its valid bit is set and its address matches;
- else the one-cycle-delayed copy of the last write, if valid and its address matches;
- else ram_data_read.
REQ-023 upd_client and upd_total SHALL equal ram_address_write and ram_data_write; upd_valid SHALL be 0 for INIT writes.
REQ-024 Back-to-back events to the same client on every cycle SHALL accumulate with no lost update.
REQ-025 ram_write_enable SHALL be 0 in any RUN cycle with no update.

Reset
REQ-026 While rst_n=0 at an edge, the following SHALL be 0: in_ready, init_done, ram_write_enable, upd_valid, sat_pulse, all address and data registers, the forwarding valid bits and the INIT counter.
REQ-027 Reset asserted mid-operation SHALL discard in-flight events, drop any write not yet presented, and restart INIT from address 0.

Configuration
REQ-028 With CANCEL_ACC_SAT_EN defined:
- if base + amount exceeds 2^D_WIDTH-1, the total SHALL clamp to all-ones;
- sat_pulse SHALL be 1 in the same cycle as that write.
REQ-029 With CANCEL_ACC_SAT_EN undefined:
- the sum SHALL wrap modulo 2^D_WIDTH;
- sat_pulse SHALL be tied to 0.

Verification
REQ-030 Reset release -> 16 writes of 0 to addresses 0..15 over 16 cycles; init_done=1 and in_ready=1 on the 17th cycle.
REQ-031 Events (client 3, amount 5) then (client 3, amount 7) on consecutive cycles -> ram_data_write 5, then 12, at address 3.
REQ-032 Events to client 2 with amounts 1, 2, 3 every cycle, interleaved with client 9 amount 4 -> client 2 totals 1, 3, 6 (two-deep forwarding exercised); client 9 total 4.
REQ-033 Client 5 holds 100, then an event with in_clear=1 and amount 50 -> write of 0, then a following event with amount 8 -> 8.
REQ-034 With CANCEL_ACC_SAT_EN, client 1 at 0xFFFF_FFF0 plus amount 0x20 -> 0xFFFF_FFFF with sat_pulse=1; without the macro -> 0x0000_0010 with sat_pulse=0.
REQ-035 rst_n pulsed low with two events in flight -> no write of those events reaches the RAM, and INIT restarts at address 0.
